// File: rtl/result_reader_if.sv
// Bus bundle between the result reader, the result SRAM read port and the
// downstream consumer of the streamed words.
interface result_reader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    // SRAM read port
    logic              sram_cs_n;
    logic              sram_we_n;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ry;
    logic [DATA_W-1:0] sram_rdata;
    // Result stream
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // The reader: owns the SRAM port and produces the stream.
    modport master (
        output sram_cs_n, sram_we_n, sram_addr, out_data, out_valid,
        input  sram_ry, sram_rdata, out_ready
    );

    // The SRAM and the stream consumer seen as one peer.
    modport slave (
        input  sram_cs_n, sram_we_n, sram_addr, out_data, out_valid,
        output sram_ry, sram_rdata, out_ready
    );
endinterface

// File: rtl/result_reader.sv
// Result SRAM read-back engine: after a start pulse, reads NUM_WORDS words
// beginning at BASE_ADDR (address wrapping modulo 2**ADDR_W), one read per
// word, and streams each word out on a valid/ready handshake.
module result_reader #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 16,
    parameter int BASE_ADDR = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    result_reader_if.master bus
);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] count;

    // Read-out FSM; every output is a register updated on the transition
    // into the state where it must hold its value.
    // NOTE: sequential state uses non-blocking (<=) so all registers sample
    // pre-edge values and the order of statements below does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.sram_cs_n <= 1'b1;
            bus.sram_we_n <= 1'b1;
            bus.sram_addr <= BASE;
            bus.out_data  <= {DATA_W{1'b0}};
            bus.out_valid <= 1'b0;
        end else begin
            // Read-only port: write enable is never asserted.
            bus.sram_we_n <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= ISSUE;
                        count         <= '0;
                        bus.sram_addr <= BASE;
                        bus.sram_cs_n <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Chip select is low for exactly the ISSUE cycle.
                    bus.sram_cs_n <= 1'b1;
                    state         <= WAIT;
                end
                WAIT: begin
                    // sram_ry is only meaningful here; elsewhere it is ignored.
                    if (bus.sram_ry) begin
                        bus.out_data  <= bus.sram_rdata;
                        bus.out_valid <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (count == LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            count         <= count + 1'b1;
                            bus.sram_addr <= bus.sram_addr + 1'b1;
                            bus.sram_cs_n <= 1'b0;
                            state         <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    // A start arriving here is dropped; only IDLE honours it.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
